// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage bridge to a variable-latency data memory bus.
// Decodes size into byte enables and lane-replicated store data, runs a
// req/ack handshake with a timeout, stalls the pipeline while the bus is
// busy and returns the load word right-aligned for the load-extension logic.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last counter value before a timeout fires; unused when TIMEOUT is 0.
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             bus_req_r;
    logic             bus_we_r;
    logic [31:0]      bus_addr_r;
    logic [3:0]       bus_be_r;
    logic [31:0]      bus_wdata_r;
    logic [1:0]       addr_lo_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_err_r;

    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic             size_bad_s;
    logic             accept_s;
    logic             timeout_s;
    logic             stall_s;
    logic             misalign_s;

    // Size decode: byte enables, lane-replicated store data, alignment check.
    always_comb begin
        be_s       = 4'b0000;
        wdata_s    = 32'h0000_0000;
        size_bad_s = 1'b0;
        case (req_func3[1:0])
            2'b00: begin
                be_s       = 4'b0001 << req_addr[1:0];
                wdata_s    = {4{req_wdata[7:0]}};
                size_bad_s = 1'b0;
            end
            2'b01: begin
                be_s       = 4'b0011 << req_addr[1:0];
                wdata_s    = {2{req_wdata[15:0]}};
                size_bad_s = req_addr[0];
            end
            2'b10: begin
                be_s       = 4'b1111;
                wdata_s    = req_wdata;
                size_bad_s = (req_addr[1:0] != 2'b00);
            end
            default: begin
                be_s       = 4'b0000;
                wdata_s    = 32'h0000_0000;
                size_bad_s = 1'b1;
            end
        endcase
    end

    // Next-state, stall and misalign decode; a misaligned request never leaves IDLE.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        timeout_s   = 1'b0;
        stall_s     = 1'b0;
        misalign_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    misalign_s  = size_bad_s;
                    accept_s    = !size_bad_s;
                    stall_s     = !size_bad_s;
                    state_nxt_s = size_bad_s ? IDLE : BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                // An ack on the final count wins over the timeout.
                if (bus_ack) begin
                    state_nxt_s = RESP;
                end else if (TO_EN && (cnt_r == TO_LAST)) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RESP: begin
                // req_valid still shows the completed instruction here.
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, bus request registers and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_be_r    <= 4'b0000;
            bus_wdata_r <= 32'h0000_0000;
            addr_lo_r   <= 2'b00;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    rsp_valid_r <= 1'b0;
                    if (accept_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= req_wr;
                        bus_addr_r  <= {req_addr[31:2], 2'b00};
                        bus_be_r    <= be_s;
                        bus_wdata_r <= wdata_s;
                        addr_lo_r   <= req_addr[1:0];
                        cnt_r       <= {CNT_W{1'b0}};
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= bus_we_r ? 32'h0000_0000
                                                : (bus_rdata >> {addr_lo_r, 3'b000});
                    end else if (timeout_s) begin
                        bus_req_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    rsp_valid_r <= 1'b0;
                end
                default: begin
                    bus_req_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall     = stall_s;
    assign misalign  = misalign_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_be    = bus_be_r;
    assign bus_wdata = bus_wdata_r;

endmodule
